// File: rtl/lfsr_pkg.sv
// Shared definitions for the LFSR random-byte arbiter: LFSR geometry,
// feedback taps, reset value, FSM state encoding and the one-step helper.
package lfsr_pkg;

  localparam int               LFSR_W     = 8;
  localparam logic [LFSR_W-1:0] LFSR_TAPS  = 8'hB8;
  localparam logic [LFSR_W-1:0] LFSR_RESET = 8'h01;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_STEP    = 2'd1,
    ST_DELIVER = 2'd2
  } state_t;

  // Fibonacci shift-left: new LSB is the XOR of bits 7, 5, 4 and 3.
  function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] s);
    return {s[LFSR_W-2:0], ^(s & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/lfsr_rr_arb.sv
// Two-way round-robin pick: a lone requester wins outright, and when both
// ask the one that was not served last time wins. Purely combinational.
module lfsr_rr_arb
  import lfsr_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  output logic       grant_idx,
  output logic       grant_valid
);

  // Resolve the winner from the request pair and the last-served pointer.
  always_comb begin
    grant_valid = |req;
    grant_idx   = 1'b0;
    case (req)
      2'b01:   grant_idx = 1'b0;
      2'b10:   grant_idx = 1'b1;
      2'b11:   grant_idx = ~last;
      default: grant_idx = 1'b0;
    endcase
  end

endmodule

// File: rtl/lfsr_arbiter.sv
// Shares one 8-bit LFSR between two requesters. Each grant advances the LFSR
// STEPS times to decorrelate consecutive bytes, then hands the state to the
// winner with a one-cycle strobe. Seeds may only be loaded while idle.
module lfsr_arbiter
  import lfsr_pkg::*;
#(
  parameter int unsigned STEPS = 8
)
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                seed_we,
  input  logic [LFSR_W-1:0]   seed,
  output logic                seed_ready,
  input  logic [1:0]          req,
  output logic [1:0]          rnd_valid,
  output logic [LFSR_W-1:0]   rnd_data,
  output logic                busy
);

  localparam logic [3:0] STEP_LOAD = 4'(STEPS - 1);

  state_t              state_q, state_d;
  logic [LFSR_W-1:0]   lfsr_q, lfsr_d;
  logic [3:0]          cnt_q, cnt_d;
  logic                grant_q, grant_d;
  logic                last_q, last_d;

  logic                arb_idx;
  logic                arb_valid;

  lfsr_rr_arb u_arb (
    .req         (req),
    .last        (last_q),
    .grant_idx   (arb_idx),
    .grant_valid (arb_valid)
  );

  // FSM state register; reset lands in IDLE without waiting for a clock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Datapath registers: LFSR, step counter, current grant, last-served pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr_q  <= LFSR_RESET;
      cnt_q   <= 4'd0;
      grant_q <= 1'b0;
      last_q  <= 1'b1;
    end else begin
      lfsr_q  <= lfsr_d;
      cnt_q   <= cnt_d;
      grant_q <= grant_d;
      last_q  <= last_d;
    end
  end

  // Next-state: a seed write holds IDLE for a cycle, so the grant waits.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (!seed_we && arb_valid) begin
          state_d = ST_STEP;
        end
      end
      ST_STEP: begin
        if (cnt_q == 4'd0) begin
          state_d = ST_DELIVER;
        end
      end
      ST_DELIVER: state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // Datapath next values; the LFSR only moves in STEP or on a seed load.
  always_comb begin
    lfsr_d  = lfsr_q;
    cnt_d   = cnt_q;
    grant_d = grant_q;
    last_d  = last_q;
    case (state_q)
      ST_IDLE: begin
        if (seed_we) begin
          lfsr_d = (seed == '0) ? LFSR_RESET : seed;
        end else if (arb_valid) begin
          grant_d = arb_idx;
          cnt_d   = STEP_LOAD;
        end
      end
      ST_STEP: begin
        lfsr_d = lfsr_next(lfsr_q);
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_DELIVER: begin
        last_d = grant_q;
      end
      default: begin
        lfsr_d = lfsr_q;
      end
    endcase
  end

  // Outputs decoded from registered state only.
  always_comb begin
    seed_ready = (state_q == ST_IDLE);
    busy       = (state_q != ST_IDLE);
    rnd_data   = lfsr_q;
    rnd_valid  = 2'b00;
    if (state_q == ST_DELIVER) begin
      rnd_valid = grant_q ? 2'b10 : 2'b01;
    end
  end

endmodule

// File: tb/tb_lfsr_arbiter.sv
// Self-checking bench for lfsr_arbiter: a directed vector table, hand-written
// corner sequences, and a randomized run against a transaction-level model.
module tb_lfsr_arbiter;

  localparam int unsigned STEPS0 = 8;
  localparam int unsigned STEPS1 = 1;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;

  logic       seed_we = 1'b0;
  logic [7:0] seed = 8'h00;
  logic [1:0] req = 2'b00;
  logic       seed_ready;
  logic [1:0] rnd_valid;
  logic [7:0] rnd_data;
  logic       busy;

  logic       seed_we1 = 1'b0;
  logic [7:0] seed1 = 8'h00;
  logic [1:0] req1 = 2'b00;
  logic       seed_ready1;
  logic [1:0] rnd_valid1;
  logic [7:0] rnd_data1;
  logic       busy1;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic       we;
    logic [7:0] sd;
    logic [1:0] rq;
    logic [1:0] ev;
    logic [7:0] ed;
    logic       eb;
    logic       er;
  } vec_t;

  vec_t vecs[$];

  lfsr_arbiter #(.STEPS(STEPS0)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .seed_we    (seed_we),
    .seed       (seed),
    .seed_ready (seed_ready),
    .req        (req),
    .rnd_valid  (rnd_valid),
    .rnd_data   (rnd_data),
    .busy       (busy)
  );

  lfsr_arbiter #(.STEPS(STEPS1)) dut1 (
    .clk        (clk),
    .rst_n      (rst_n),
    .seed_we    (seed_we1),
    .seed       (seed1),
    .seed_ready (seed_ready1),
    .req        (req1),
    .rnd_valid  (rnd_valid1),
    .rnd_data   (rnd_data1),
    .busy       (busy1)
  );

  always #5 clk = ~clk;

  // Advance an LFSR value n times using the documented feedback rule.
  function automatic logic [7:0] lfsr_n(input logic [7:0] s, input int n);
    logic [7:0] v;
    v = s;
    for (int i = 0; i < n; i++) begin
      v = {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
    end
    return v;
  endfunction

  task automatic checkValue(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic checkOutput(input string name, input logic [1:0] ev, input logic [7:0] ed,
                             input logic eb, input logic er);
    checkValue({name, ".rnd_valid"},  {6'd0, rnd_valid},  {6'd0, ev});
    checkValue({name, ".rnd_data"},   rnd_data,           ed);
    checkValue({name, ".busy"},       {7'd0, busy},       {7'd0, eb});
    checkValue({name, ".seed_ready"}, {7'd0, seed_ready}, {7'd0, er});
  endtask

  task automatic applyStimulus(input logic we, input logic [7:0] sd, input logic [1:0] rq);
    seed_we = we;
    seed    = sd;
    req     = rq;
    @(posedge clk);
    #1;
  endtask

  task automatic addVec(input logic we, input logic [7:0] sd, input logic [1:0] rq,
                        input logic [1:0] ev, input logic [7:0] ed, input logic eb, input logic er);
    vec_t v;
    v.we = we; v.sd = sd; v.rq = rq; v.ev = ev; v.ed = ed; v.eb = eb; v.er = er;
    vecs.push_back(v);
  endtask

  task automatic doReset();
    seed_we = 1'b0; seed = 8'h00; req = 2'b00; req1 = 2'b00;
    @(negedge clk);
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int cyc;
    int n_del;
    int last_cyc;
    logic [7:0] exp_data;
    logic [1:0] exp_v;
    logic saw_valid;
    logic [7:0] m_lfsr;
    logic [7:0] m_start;
    logic       m_last;
    logic       m_gnt;
    int         m_rem;
    logic       we;
    logic [7:0] sd;
    logic [1:0] rq;
    logic [1:0] ev;
    logic [7:0] ed;

    // Directed table: STEPS=8 grant from reset, seed handling, seed/req collision.
    for (int k = 0; k < 8; k++) addVec(1'b0, 8'h00, 2'b01, 2'b00, lfsr_n(8'h01, k), 1'b1, 1'b0);
    addVec(1'b0, 8'h00, 2'b00, 2'b01, 8'h1C, 1'b1, 1'b0);
    addVec(1'b0, 8'h00, 2'b00, 2'b00, 8'h1C, 1'b0, 1'b1);
    addVec(1'b1, 8'h00, 2'b00, 2'b00, 8'h01, 1'b0, 1'b1);
    addVec(1'b1, 8'h08, 2'b00, 2'b00, 8'h08, 1'b0, 1'b1);
    addVec(1'b0, 8'h00, 2'b10, 2'b00, 8'h08, 1'b1, 1'b0);
    addVec(1'b1, 8'hFF, 2'b10, 2'b00, 8'h11, 1'b1, 1'b0);
    for (int k = 2; k < 8; k++) addVec(1'b1, 8'h3C, 2'b00, 2'b00, lfsr_n(8'h08, k), 1'b1, 1'b0);
    addVec(1'b0, 8'h00, 2'b00, 2'b10, lfsr_n(8'h08, 8), 1'b1, 1'b0);
    addVec(1'b0, 8'h00, 2'b00, 2'b00, lfsr_n(8'h08, 8), 1'b0, 1'b1);
    addVec(1'b1, 8'h5A, 2'b10, 2'b00, 8'h5A, 1'b0, 1'b1);
    addVec(1'b0, 8'h00, 2'b10, 2'b00, 8'h5A, 1'b1, 1'b0);
    for (int k = 1; k < 8; k++) addVec(1'b0, 8'h00, 2'b00, 2'b00, lfsr_n(8'h5A, k), 1'b1, 1'b0);
    addVec(1'b0, 8'h00, 2'b00, 2'b10, lfsr_n(8'h5A, 8), 1'b1, 1'b0);
    addVec(1'b0, 8'h00, 2'b00, 2'b00, lfsr_n(8'h5A, 8), 0, 1'b1);

    // Reset values, observed while reset is still asserted.
    #2;
    rst_n = 1'b0;
    #2;
    checkOutput("reset", 2'b00, 8'h01, 1'b0, 1'b1);
    checkValue("reset1.rnd_data", rnd_data1, 8'h01);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("post_reset_idle", 2'b00, 8'h01, 1'b0, 1'b1);

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].we, vecs[i].sd, vecs[i].rq);
      checkOutput($sformatf("vec%0d", i), vecs[i].ev, vecs[i].ed, vecs[i].eb, vecs[i].er);
    end

    // Both requesting continuously: alternate 01/10, one byte every STEPS+2 cycles.
    doReset();
    req = 2'b11;
    cyc = 0; n_del = 0; last_cyc = 0;
    exp_data = 8'h01; exp_v = 2'b01;
    while (n_del < 4 && cyc < 80) begin
      @(posedge clk);
      #1;
      if (rnd_valid != 2'b00) begin
        exp_data = lfsr_n(exp_data, STEPS0);
        checkValue("rr_grant", {6'd0, rnd_valid}, {6'd0, exp_v});
        checkValue("rr_data", rnd_data, exp_data);
        if (n_del == 0) checkValue("rr_first_latency", 8'(cyc), 8'(STEPS0));
        else            checkValue("rr_spacing", 8'(cyc - last_cyc), 8'(STEPS0 + 2));
        last_cyc = cyc;
        n_del++;
        exp_v = ~exp_v;
      end
      cyc++;
    end
    if (n_del < 4) begin
      checks++;
      errors++;
      $display("[TB] FAIL rr_timeout: got %0d deliveries expected 4", n_del);
    end

    // Asynchronous reset in the middle of STEP drops the grant.
    doReset();
    req = 2'b01;
    repeat (5) begin
      @(posedge clk);
      #1;
    end
    checkValue("midstep.busy", {7'd0, busy}, 8'd1);
    req = 2'b00;
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("async_reset", 2'b00, 8'h01, 1'b0, 1'b1);
    #1;
    rst_n = 1'b1;
    saw_valid = 1'b0;
    repeat (12) begin
      @(posedge clk);
      #1;
      if (rnd_valid != 2'b00) saw_valid = 1'b1;
    end
    checkValue("reset_no_valid", {7'd0, saw_valid}, 8'd0);
    checkValue("reset_lfsr", rnd_data, 8'h01);

    // STEPS=1 instance: strobe right after the single advance.
    doReset();
    req1 = 2'b10;
    @(posedge clk);
    #1;
    req1 = 2'b00;
    checkValue("steps1.busy", {7'd0, busy1}, 8'd1);
    checkValue("steps1.step_valid", {6'd0, rnd_valid1}, 8'd0);
    @(posedge clk);
    #1;
    checkValue("steps1.valid", {6'd0, rnd_valid1}, 8'h02);
    checkValue("steps1.data", rnd_data1, 8'h02);
    @(posedge clk);
    #1;
    checkValue("steps1.idle", {7'd0, busy1}, 8'd0);

    // Randomized run against a transaction-level model.
    doReset();
    m_lfsr = 8'h01; m_start = 8'h01; m_last = 1'b1; m_gnt = 1'b0; m_rem = 0;
    repeat (600) begin
      we = ($urandom_range(0, 7) == 0);
      sd = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
      rq = 2'($urandom_range(0, 3));
      if (m_rem == 0) begin
        if (we) begin
          m_lfsr = (sd == 8'h00) ? 8'h01 : sd;
        end else if (rq != 2'b00) begin
          m_gnt   = (rq == 2'b11) ? ~m_last : rq[1];
          m_start = m_lfsr;
          m_rem   = int'(STEPS0) + 1;
        end
      end else begin
        m_rem--;
        if (m_rem == 0) begin
          m_last = m_gnt;
          m_lfsr = lfsr_n(m_start, int'(STEPS0));
        end
      end
      applyStimulus(we, sd, rq);
      if (m_rem == 0) begin
        checkOutput("rand", 2'b00, m_lfsr, 1'b0, 1'b1);
      end else begin
        ev = (m_rem == 1) ? (m_gnt ? 2'b10 : 2'b01) : 2'b00;
        ed = lfsr_n(m_start, int'(STEPS0) + 1 - m_rem);
        checkOutput("rand", ev, ed, 1'b1, 1'b0);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
